// File: rtl/neuron_input_sequencer_pkg.sv
// Shared definitions for the neuron operand sequencer.
// The operand width lives here so the Neuron datapath and this block agree.
package neuron_input_sequencer_pkg;

    localparam int NEURON_N = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } seq_state_t;

endpackage

// File: rtl/neuron_input_sequencer_operand_bank.sv
// DEPTH x 2N operand register file.
// One synchronous write port, one combinational read port, asynchronous clear.
module neuron_input_sequencer_operand_bank #(
    parameter int N     = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [N-1:0]             wr_x,
    input  logic [N-1:0]             wr_w,
    input  logic [$clog2(DEPTH)-1:0] rd_addr,
    output logic [N-1:0]             rd_x,
    output logic [N-1:0]             rd_w
);

    logic [N-1:0] bank_x [DEPTH];
    logic [N-1:0] bank_w [DEPTH];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank_x[i] <= '0;
                bank_w[i] <= '0;
            end
        end else if (wr_en) begin
            bank_x[wr_addr] <= wr_x;
            bank_w[wr_addr] <= wr_w;
        end
    end

    assign rd_x = bank_x[rd_addr];
    assign rd_w = bank_w[rd_addr];

endmodule

// File: rtl/neuron_input_sequencer.sv
// Streams DEPTH stored input/weight pairs into the Neuron on a start edge,
// then captures its result or flags a timeout.
//
// state   | meaning
// S_IDLE  | host may write the bank; waiting for a rising edge on st
// S_ISSUE | one operand pair per cycle; leaves the cycle after op_last
// S_WAIT  | waiting for n_done, bounded by TIMEOUT cycles
module neuron_input_sequencer
    import neuron_input_sequencer_pkg::*;
#(
    parameter int N       = NEURON_N,
    parameter int DEPTH   = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [$clog2(DEPTH)-1:0] wr_addr,
    input  logic [N-1:0]             wr_x,
    input  logic [N-1:0]             wr_w,
    input  logic                     st,
    output logic                     busy,
    output logic [N-1:0]             x_out,
    output logic [N-1:0]             w_out,
    output logic                     op_valid,
    output logic                     op_last,
    input  logic                     n_done,
    input  logic [N-1:0]             n_result,
    output logic [N-1:0]             result,
    output logic                     result_valid,
    output logic                     err
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(TIMEOUT) + 1;
    localparam logic [AW-1:0] IDX_LAST = AW'(DEPTH - 1);
    localparam logic [TW-1:0] TCNT_LAST = TW'(TIMEOUT - 1);

    seq_state_t    state;
    logic          st_q;
    logic          start;
    logic [AW-1:0] idx;
    logic [TW-1:0] tcnt;
    logic [N-1:0]  rd_x;
    logic [N-1:0]  rd_w;
    logic          bank_we;

    assign start   = st & ~st_q;
    // Writes land only in IDLE, including the cycle a start is accepted.
    assign bank_we = wr_en & (state == S_IDLE);

    neuron_input_sequencer_operand_bank #(
        .N     (N),
        .DEPTH (DEPTH)
    ) u_bank (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (bank_we),
        .wr_addr (wr_addr),
        .wr_x    (wr_x),
        .wr_w    (wr_w),
        .rd_addr (idx),
        .rd_x    (rd_x),
        .rd_w    (rd_w)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= S_IDLE;
            st_q         <= 1'b0;
            busy         <= 1'b0;
            x_out        <= '0;
            w_out        <= '0;
            op_valid     <= 1'b0;
            op_last      <= 1'b0;
            result       <= '0;
            result_valid <= 1'b0;
            err          <= 1'b0;
            idx          <= '0;
            tcnt         <= '0;
        end else begin
            st_q         <= st;
            result_valid <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        state   <= S_ISSUE;
                        busy    <= 1'b1;
                        idx     <= '0;
                        tcnt    <= '0;
                        err     <= 1'b0;
                        op_last <= 1'b0;
                    end
                end
                S_ISSUE: begin
                    if (op_last) begin
                        state    <= S_WAIT;
                        op_valid <= 1'b0;
                        op_last  <= 1'b0;
                        tcnt     <= '0;
                    end else begin
                        x_out    <= rd_x;
                        w_out    <= rd_w;
                        op_valid <= 1'b1;
                        op_last  <= (idx == IDX_LAST);
                        idx      <= idx + AW'(1);
                    end
                end
                S_WAIT: begin
                    // A completion on the terminal cycle beats the timeout.
                    if (n_done) begin
                        result       <= n_result;
                        result_valid <= 1'b1;
                        busy         <= 1'b0;
                        state        <= S_IDLE;
                    end else if (tcnt == TCNT_LAST) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_neuron_input_sequencer.sv
// Self-checking bench for neuron_input_sequencer against a bank/stream model.
module tb_neuron_input_sequencer;

    localparam int N       = 16;
    localparam int DEPTH   = 8;
    localparam int TIMEOUT = 16;
    localparam int AW      = 3;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [N-1:0]  wr_x = '0;
    logic [N-1:0]  wr_w = '0;
    logic          st = 1'b0;
    logic          n_done = 1'b0;
    logic [N-1:0]  n_result = '0;
    logic          busy, op_valid, op_last, result_valid, err;
    logic [N-1:0]  x_out, w_out, result;

    int vectors = 0;
    int miscompares = 0;

    logic [N-1:0] mx [DEPTH];
    logic [N-1:0] mw [DEPTH];
    logic [N-1:0] exp_result;

    logic [N-1:0] sx [$];
    logic [N-1:0] sw [$];
    bit           sl [$];
    int           first_c;
    bit           strm_timeout;
    bit           saw_rv;
    bit           busy_drop;

    always #5 clk = ~clk;

    neuron_input_sequencer #(
        .N       (N),
        .DEPTH   (DEPTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_x         (wr_x),
        .wr_w         (wr_w),
        .st           (st),
        .busy         (busy),
        .x_out        (x_out),
        .w_out        (w_out),
        .op_valid     (op_valid),
        .op_last      (op_last),
        .n_done       (n_done),
        .n_result     (n_result),
        .result       (result),
        .result_valid (result_valid),
        .err          (err)
    );

    task automatic write_pair(input int a, input logic [N-1:0] x, input logic [N-1:0] w);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = AW'(a); wr_x = x; wr_w = w;
        mx[a] = x; mw[a] = w;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    // Pulses (or holds) st and records the operand stream; returns at the
    // first cycle after the stream, which is the first WAIT cycle.
    task automatic run_stream(input bit hold, input bit wr_at_start,
                              input bit wr_mid, input bit nd_mid);
        sx.delete(); sw.delete(); sl.delete();
        first_c = -1; strm_timeout = 1'b1; saw_rv = 1'b0; busy_drop = 1'b0;
        @(negedge clk);
        st = 1'b1;
        if (wr_at_start) begin
            wr_en = 1'b1; wr_addr = '0; wr_x = N'($urandom); wr_w = N'($urandom);
            mx[0] = wr_x; mw[0] = wr_w;
        end
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (!hold) st = 1'b0;
            wr_en = 1'b0;
            n_done = 1'b0;
            if (result_valid) saw_rv = 1'b1;
            if (!busy) busy_drop = 1'b1;
            if (op_valid) begin
                if (first_c < 0) first_c = c;
                sx.push_back(x_out); sw.push_back(w_out); sl.push_back(op_last);
            end else if (first_c >= 0) begin
                strm_timeout = 1'b0;
                break;
            end
            if (wr_mid && c == 3) begin
                wr_en = 1'b1; wr_addr = AW'(3); wr_x = N'($urandom); wr_w = N'($urandom);
            end
            if (nd_mid && c == 4) begin
                n_done = 1'b1; n_result = N'($urandom);
            end
        end
    endtask

    task automatic answer(input int delay, input logic [N-1:0] val);
        repeat (delay) @(negedge clk);
        n_done = 1'b1; n_result = val;
        @(negedge clk);
        n_done = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        vectors++;
        if ({busy, op_valid, op_last, result_valid, err} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_flags got %b want 00000", {busy, op_valid, op_last, result_valid, err});
        end
        vectors++;
        if ({x_out, w_out, result} !== '0) begin
            miscompares++;
            $display("FAIL reset_data got x=%h w=%h r=%h want 0", x_out, w_out, result);
        end
        for (int i = 0; i < DEPTH; i++) begin mx[i] = '0; mw[i] = '0; end
        exp_result = '0;
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_load_stream();
        for (int i = 0; i < DEPTH; i++) write_pair(i, N'(i + 1), N'(2 * i));
        run_stream(1'b0, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (strm_timeout || sx.size() != DEPTH || first_c != 2) begin
            miscompares++;
            $display("FAIL load_shape got n=%0d first=%0d to=%0d want n=8 first=2", sx.size(), first_c, strm_timeout);
        end
        for (int i = 0; i < DEPTH && i < sx.size(); i++) begin
            vectors++;
            if (sx[i] !== N'(i + 1) || sw[i] !== N'(2 * i) || sl[i] !== (i == DEPTH - 1)) begin
                miscompares++;
                $display("FAIL load_pair%0d got x=%0d w=%0d l=%0d want x=%0d w=%0d l=%0d",
                         i, sx[i], sw[i], sl[i], i + 1, 2 * i, i == DEPTH - 1);
            end
        end
        vectors++;
        if (busy_drop || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL load_busy got drop=%0d busy=%b want busy held", busy_drop, busy);
        end
        answer(3, 16'h00F0);
        exp_result = 16'h00F0;
        vectors++;
        if (result_valid !== 1'b1 || result !== 16'h00F0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL capture got rv=%b r=%h busy=%b want rv=1 r=00f0 busy=0", result_valid, result, busy);
        end
        @(negedge clk);
        vectors++;
        if (result_valid !== 1'b0 || result !== 16'h00F0) begin
            miscompares++;
            $display("FAIL capture_pulse got rv=%b r=%h want rv=0 r=00f0", result_valid, result);
        end
    endtask

    task automatic test_random_streams();
        logic [N-1:0] v;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < DEPTH; i++) write_pair(i, N'($urandom), N'($urandom));
            run_stream(1'b0, 1'b0, 1'b0, 1'b0);
            vectors++;
            if (strm_timeout || sx.size() != DEPTH) begin
                miscompares++;
                $display("FAIL rand%0d_len got %0d want 8", k, sx.size());
            end
            for (int i = 0; i < DEPTH && i < sx.size(); i++) begin
                vectors++;
                if (sx[i] !== mx[i] || sw[i] !== mw[i] || sl[i] !== (i == DEPTH - 1)) begin
                    miscompares++;
                    $display("FAIL rand%0d_pair%0d got x=%h w=%h want x=%h w=%h", k, i, sx[i], sw[i], mx[i], mw[i]);
                end
            end
            v = N'($urandom);
            answer($urandom_range(0, 10), v);
            exp_result = v;
            vectors++;
            if (result_valid !== 1'b1 || result !== v || err !== 1'b0) begin
                miscompares++;
                $display("FAIL rand%0d_result got rv=%b r=%h err=%b want rv=1 r=%h err=0", k, result_valid, result, err, v);
            end
        end
    endtask

    task automatic test_timeout();
        run_stream(1'b0, 1'b0, 1'b0, 1'b0);
        repeat (15) @(negedge clk);
        vectors++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL timeout_early got err=%b busy=%b want err=0 busy=1", err, busy);
        end
        @(negedge clk);
        vectors++;
        if (err !== 1'b1 || busy !== 1'b0 || result !== exp_result || result_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL timeout got err=%b busy=%b r=%h rv=%b want err=1 busy=0 r=%h rv=0",
                     err, busy, result, result_valid, exp_result);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (err !== 1'b1) begin
            miscompares++;
            $display("FAIL err_sticky got %b want 1", err);
        end
        run_stream(1'b0, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            miscompares++;
            $display("FAIL err_clear got err=%b busy=%b want err=0 busy=1", err, busy);
        end
        answer(1, 16'h1234);
        exp_result = 16'h1234;
    endtask

    task automatic test_hold_start();
        bit extra;
        run_stream(1'b1, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (strm_timeout || sx.size() != DEPTH) begin
            miscompares++;
            $display("FAIL hold_len got %0d want 8", sx.size());
        end
        answer(2, 16'h0BEE);
        exp_result = 16'h0BEE;
        extra = 1'b0;
        for (int c = 0; c < 38; c++) begin
            @(negedge clk);
            if (op_valid || busy) extra = 1'b1;
        end
        st = 1'b0;
        vectors++;
        if (extra) begin
            miscompares++;
            $display("FAIL hold_single got retrigger=1 want 0");
        end
    endtask

    task automatic test_ignored_events();
        run_stream(1'b0, 1'b0, 1'b1, 1'b1);
        vectors++;
        if (saw_rv || result !== exp_result) begin
            miscompares++;
            $display("FAIL ndone_issue got rv_seen=%0d r=%h want 0 r=%h", saw_rv, result, exp_result);
        end
        answer(0, 16'h0077);
        exp_result = 16'h0077;
        run_stream(1'b0, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (sx.size() != DEPTH || sx[3] !== mx[3] || sw[3] !== mw[3]) begin
            miscompares++;
            $display("FAIL wr_busy got x3=%h w3=%h want x3=%h w3=%h", sx[3], sw[3], mx[3], mw[3]);
        end
        answer(0, 16'h0078);
        exp_result = 16'h0078;
    endtask

    task automatic test_write_and_start();
        run_stream(1'b0, 1'b1, 1'b0, 1'b0);
        vectors++;
        if (sx.size() != DEPTH || sx[0] !== mx[0] || sw[0] !== mw[0]) begin
            miscompares++;
            $display("FAIL wr_start got x0=%h w0=%h want x0=%h w0=%h", sx[0], sw[0], mx[0], mw[0]);
        end
        answer(2, 16'h5A5A);
        exp_result = 16'h5A5A;
    endtask

    task automatic test_reset_mid();
        int nv;
        bit reached;
        nv = 0; reached = 1'b0;
        @(negedge clk);
        st = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            st = 1'b0;
            if (op_valid) nv++;
            if (nv == 4) begin reached = 1'b1; break; end
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (!reached || op_valid !== 1'b0 || busy !== 1'b0 || result !== '0 || x_out !== '0) begin
            miscompares++;
            $display("FAIL reset_mid got reached=%0d ov=%b busy=%b r=%h x=%h want ov=0 busy=0 r=0 x=0",
                     reached, op_valid, busy, result, x_out);
        end
        for (int i = 0; i < DEPTH; i++) begin mx[i] = '0; mw[i] = '0; end
        exp_result = '0;
        @(negedge clk);
        rst = 1'b1;
        run_stream(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) begin
            vectors++;
            if (i >= sx.size() || sx[i] !== '0 || sw[i] !== '0) begin
                miscompares++;
                $display("FAIL cleared_pair%0d got n=%0d want x=0 w=0", i, sx.size());
            end
        end
        answer(0, 16'h0001);
        exp_result = 16'h0001;
    endtask

    task automatic test_collision();
        run_stream(1'b0, 1'b0, 1'b0, 1'b0);
        answer(TIMEOUT - 1, 16'hFFFF);
        exp_result = 16'hFFFF;
        vectors++;
        if (result_valid !== 1'b1 || result !== 16'hFFFF || err !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL collision got rv=%b r=%h err=%b busy=%b want rv=1 r=ffff err=0 busy=0",
                     result_valid, result, err, busy);
        end
    endtask

    initial begin
        test_reset();
        test_load_stream();
        test_random_streams();
        test_timeout();
        test_hold_start();
        test_ignored_events();
        test_write_and_start();
        test_reset_mid();
        test_collision();
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
